instr_fetch_seq: RTL

Instruction loader and sequencer feeding the processor core's 32-bit instruction register. Assembles instructions from 16-bit halves on a load port and stores them in a small program buffer. On `start`, it issues the stored program in order to the execute core through a valid/ready handshake, then signals completion.

---
 rtl/instr_fetch_seq.sv | 135 +++++++++++++
 1 files changed

// File: rtl/instr_fetch_seq.sv
// instr_fetch_seq: loads 32-bit instructions as two 16-bit halves (high half first)
// into a DEPTH-entry program buffer. On start it issues the stored program in order
// over a valid/ready handshake, then pulses done for one cycle.
// Optional feature macro: FETCH_HALT_EN. When it is defined, a stored word whose
// op field [31:27] is all ones acts as HALT and ends the program without being issued.
module instr_fetch_seq #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          sys_rst,
   input  logic          load_valid,
   output logic          load_ready,
   input  logic [15:0]   load_data,
   input  logic          clr,
   input  logic          start,
   output logic          issue_valid,
   input  logic          issue_ready,
   output logic [31:0]   issue_ir,
   output logic [AW-1:0] pc,
   output logic [AW:0]   prog_len,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t        state, state_next;
   logic [31:0]   mem [DEPTH];
   logic [15:0]   hi;
   logic          half;
   logic          load_fire;
   logic          start_ok;
   logic          hs;
   logic          last;
   logic          first_halt;
   logic          next_halt;
   logic [AW-1:0] nxt_idx;

   assign load_ready  = (state == S_IDLE) && (prog_len < (AW+1)'(DEPTH));
   assign issue_valid = (state == S_RUN);
   assign busy        = (state != S_IDLE);
   assign done        = (state == S_DONE);

   // clr wins over a simultaneous load or start
   assign load_fire = load_valid && load_ready && !clr;
   assign start_ok  = (state == S_IDLE) && !clr && start &&
                      (prog_len != '0) && !half;
   assign hs        = issue_valid && issue_ready;
   assign last      = ({1'b0, pc} == (prog_len - (AW+1)'(1)));
   assign nxt_idx   = pc + AW'(1);

`ifdef FETCH_HALT_EN
   assign first_halt = (mem[0][31:27] == 5'b11111);
   assign next_halt  = (mem[nxt_idx][31:27] == 5'b11111);
`else
   assign first_halt = 1'b0;
   assign next_halt  = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (sys_rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode: IDLE -> RUN (or DONE on an immediate HALT) -> DONE -> IDLE
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (start_ok) begin
               state_next = first_halt ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (hs && (last || next_halt)) begin
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Program buffer write; contents are not reset, prog_len gates visibility
   always_ff @(posedge clk) begin
      if (load_fire && half) begin
         mem[prog_len[AW-1:0]] <= {hi, load_data};
      end
   end

   // Loader bookkeeping and issue register / program counter
   always_ff @(posedge clk) begin
      if (sys_rst) begin
         hi       <= '0;
         half     <= 1'b0;
         prog_len <= '0;
         pc       <= '0;
         issue_ir <= '0;
      end else begin
         if (state == S_IDLE) begin
            if (clr) begin
               prog_len <= '0;
               half     <= 1'b0;
            end else if (load_fire) begin
               half <= ~half;
               if (!half) begin
                  hi <= load_data;
               end else begin
                  prog_len <= prog_len + (AW+1)'(1);
               end
            end
            if (start_ok) begin
               pc       <= '0;
               issue_ir <= mem[0];
            end
         end else if (state == S_RUN) begin
            // pc only advances onto a word that will actually be presented
            if (hs && !last && !next_halt) begin
               pc       <= nxt_idx;
               issue_ir <= mem[nxt_idx];
            end
         end
      end
   end

endmodule
